sram_fifo_ctrl: RTL

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

---
 rtl/sram_fifo_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller around a 1R1W SRAM macro with a 2-entry registered output skid buffer.
// Optional SRAM_FIFO_CTRL_BYPASS_EN: words entering an empty FIFO skip the SRAM.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 22,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  sram_wr_csb_o,
    output logic [ADDR_WIDTH-1:0] sram_wr_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wr_data_o,
    output logic                  sram_rd_csb_o,
    output logic [ADDR_WIDTH-1:0] sram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] sram_rd_data_i,
    output logic [4:0]            count_o
);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_sram_cnt;
    logic                  r_rd_inflight;
    logic [1:0]            r_skid_cnt;
    logic [DATA_WIDTH-1:0] r_skid0, r_skid1;

    logic                  w_push, w_pop, w_rd, w_wr, w_byp, w_app;
    logic [2:0]            w_room;
    logic [DATA_WIDTH-1:0] w_app_data;
    logic [1:0]            w_nxt_cnt;
    logic [DATA_WIDTH-1:0] w_nxt0, w_nxt1;

    assign in_ready_o  = (r_sram_cnt < DEPTH_C);
    assign out_valid_o = (r_skid_cnt != 2'd0);
    assign out_data_o  = r_skid0;
    assign count_o     = 5'(r_sram_cnt) + 5'(r_rd_inflight) + 5'(r_skid_cnt);

    assign w_push = in_valid_i & in_ready_o & ~rst_i;
    assign w_pop  = out_valid_o & out_ready_i;
    // Skid entries that may still be claimed after this cycle's pop.
    assign w_room = 3'd2 + {2'b00, w_pop};
    assign w_rd   = ~rst_i & (r_sram_cnt != '0)
                  & (({1'b0, r_skid_cnt} + {2'b00, r_rd_inflight}) < w_room);

`ifdef SRAM_FIFO_CTRL_BYPASS_EN
    assign w_byp = w_push & (r_sram_cnt == '0) & ~r_rd_inflight & ({1'b0, r_skid_cnt} < w_room);
`else
    assign w_byp = 1'b0;
`endif

    assign w_wr       = w_push & ~w_byp;
    assign w_app      = r_rd_inflight | w_byp;
    // Bypass only fires with no read in flight, so the two sources never collide.
    assign w_app_data = r_rd_inflight ? sram_rd_data_i : in_data_i;

    assign sram_wr_csb_o  = ~w_wr;
    assign sram_wr_addr_o = r_wr_ptr;
    assign sram_wr_data_o = in_data_i;
    assign sram_rd_csb_o  = ~w_rd;
    assign sram_rd_addr_o = r_rd_ptr;

    always_comb begin
        w_nxt_cnt = r_skid_cnt;
        w_nxt0    = r_skid0;
        w_nxt1    = r_skid1;
        if (w_pop) begin
            w_nxt0    = r_skid1;
            w_nxt_cnt = r_skid_cnt - 2'd1;
        end
        if (w_app) begin
            if (w_nxt_cnt == 2'd0) w_nxt0 = w_app_data;
            else                   w_nxt1 = w_app_data;
            w_nxt_cnt = w_nxt_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_sram_cnt    <= '0;
            r_rd_inflight <= 1'b0;
            r_skid_cnt    <= 2'd0;
        end else begin
            r_wr_ptr      <= r_wr_ptr + ADDR_WIDTH'(w_wr);
            r_rd_ptr      <= r_rd_ptr + ADDR_WIDTH'(w_rd);
            r_sram_cnt    <= r_sram_cnt + (ADDR_WIDTH+1)'(w_wr) - (ADDR_WIDTH+1)'(w_rd);
            r_rd_inflight <= w_rd;
            r_skid_cnt    <= w_nxt_cnt;
            r_skid0       <= w_nxt0;
            r_skid1       <= w_nxt1;
        end
    end
endmodule
